// File: rtl/otsu_pkg.sv
// Shared Otsu pipeline types and default sizing, used by the histogram,
// prefix and variance blocks.
package otsu_pkg;

   localparam int OTSU_NUM_BINS        = 256;
   localparam int OTSU_COUNT_WIDTH     = 32;
   localparam int OTSU_INTENSITY_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } otsu_state_e;

endpackage

// File: rtl/otsu_class_stats.sv
// Background-class statistics: w2/m2 = frame totals minus the cumulative values.
// Optional macro SATURATE_EN clamps the results to 0 instead of wrapping.
module otsu_class_stats
   import otsu_pkg::*;
#(
   parameter int COUNT_WIDTH     = OTSU_COUNT_WIDTH,
   parameter int INTENSITY_WIDTH = OTSU_INTENSITY_WIDTH
) (
   input  logic [COUNT_WIDTH-1:0]     total_w,
   input  logic [INTENSITY_WIDTH-1:0] total_m,
   input  logic [COUNT_WIDTH-1:0]     cum_w,
   input  logic [INTENSITY_WIDTH-1:0] cum_m,
   output logic [COUNT_WIDTH-1:0]     w2,
   output logic [INTENSITY_WIDTH-1:0] m2
);

`ifdef SATURATE_EN
   assign w2 = (cum_w > total_w) ? '0 : total_w - cum_w;
   assign m2 = (cum_m > total_m) ? '0 : total_m - cum_m;
`else
   assign w2 = total_w - cum_w;
   assign m2 = total_m - cum_m;
`endif

endmodule

// File: rtl/otsu_prefix_engine.sv
// Streaming prefix-sum stage for Otsu thresholding: raw bins in, per-bin class
// statistics out. Optional macro SATURATE_EN makes accumulators and w2/m2 saturate.
module otsu_prefix_engine
   import otsu_pkg::*;
#(
   parameter int  NUM_BINS        = OTSU_NUM_BINS,
   parameter int  COUNT_WIDTH     = OTSU_COUNT_WIDTH,
   parameter int  INTENSITY_WIDTH = OTSU_INTENSITY_WIDTH,
   localparam int BIN_WIDTH       = $clog2(NUM_BINS)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       abort,
   input  logic [COUNT_WIDTH-1:0]     total_pixels,
   input  logic [INTENSITY_WIDTH-1:0] total_intensity_sum,
   input  logic [COUNT_WIDTH-1:0]     in_count,
   input  logic                       in_valid,
   input  logic                       in_last,
   output logic                       in_ready,
   output logic [COUNT_WIDTH-1:0]     w1,
   output logic [INTENSITY_WIDTH-1:0] m1,
   output logic [COUNT_WIDTH-1:0]     w2,
   output logic [INTENSITY_WIDTH-1:0] m2,
   output logic [BIN_WIDTH-1:0]       out_bin,
   output logic                       out_valid,
   output logic                       out_last,
   input  logic                       out_ready,
   output logic                       done,
   output logic                       err
);

   otsu_state_e                state_reg;
   logic [COUNT_WIDTH-1:0]     total_w_reg;
   logic [INTENSITY_WIDTH-1:0] total_m_reg;
   logic [COUNT_WIDTH-1:0]     acc_w_reg;
   logic [INTENSITY_WIDTH-1:0] acc_m_reg;
   logic [BIN_WIDTH-1:0]       bin_reg;
   logic                       last_taken_reg;

   logic [COUNT_WIDTH-1:0]     acc_w_next;
   logic [INTENSITY_WIDTH-1:0] acc_m_next;
   logic [INTENSITY_WIDTH-1:0] weighted_count;
   logic [COUNT_WIDTH-1:0]     w2_next;
   logic [INTENSITY_WIDTH-1:0] m2_next;
   logic                       accept;
   logic                       bin_is_final;
   logic                       beat_last;
   logic                       frame_err;

   // Once the final bin is in, stop taking input until the next start.
   assign in_ready = (state_reg == RUN) && !last_taken_reg && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   // Truncating both factors first keeps the product modulo 2^INTENSITY_WIDTH.
   assign weighted_count = INTENSITY_WIDTH'(in_count) * INTENSITY_WIDTH'(bin_reg);

`ifdef SATURATE_EN
   logic [COUNT_WIDTH:0]     sum_w;
   logic [INTENSITY_WIDTH:0] sum_m;

   assign sum_w      = {1'b0, acc_w_reg} + {1'b0, in_count};
   assign sum_m      = {1'b0, acc_m_reg} + {1'b0, weighted_count};
   assign acc_w_next = sum_w[COUNT_WIDTH] ? '1 : sum_w[COUNT_WIDTH-1:0];
   assign acc_m_next = sum_m[INTENSITY_WIDTH] ? '1 : sum_m[INTENSITY_WIDTH-1:0];
`else
   assign acc_w_next = acc_w_reg + in_count;
   assign acc_m_next = acc_m_reg + weighted_count;
`endif

   assign bin_is_final = (bin_reg == BIN_WIDTH'(NUM_BINS - 1));
   assign beat_last    = in_last || bin_is_final;
   assign frame_err    = in_last != bin_is_final;

   otsu_class_stats #(
      .COUNT_WIDTH     (COUNT_WIDTH),
      .INTENSITY_WIDTH (INTENSITY_WIDTH)
   ) u_class_stats (
      .total_w (total_w_reg),
      .total_m (total_m_reg),
      .cum_w   (acc_w_next),
      .cum_m   (acc_m_next),
      .w2      (w2_next),
      .m2      (m2_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         total_w_reg    <= '0;
         total_m_reg    <= '0;
         acc_w_reg      <= '0;
         acc_m_reg      <= '0;
         bin_reg        <= '0;
         last_taken_reg <= 1'b0;
         w1             <= '0;
         m1             <= '0;
         w2             <= '0;
         m2             <= '0;
         out_bin        <= '0;
         out_valid      <= 1'b0;
         out_last       <= 1'b0;
         done           <= 1'b0;
         err            <= 1'b0;
      end else if (abort) begin
         state_reg      <= IDLE;
         last_taken_reg <= 1'b0;
         out_valid      <= 1'b0;
         out_last       <= 1'b0;
         done           <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  total_w_reg    <= total_pixels;
                  total_m_reg    <= total_intensity_sum;
                  acc_w_reg      <= '0;
                  acc_m_reg      <= '0;
                  bin_reg        <= '0;
                  last_taken_reg <= 1'b0;
                  err            <= 1'b0;
                  state_reg      <= RUN;
               end
            end

            RUN: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  if (out_last) begin
                     out_last  <= 1'b0;
                     done      <= 1'b1;
                     state_reg <= DONE;
                  end
               end
               // A new beat can only arrive while the last one is not pending.
               if (accept) begin
                  acc_w_reg <= acc_w_next;
                  acc_m_reg <= acc_m_next;
                  w1        <= acc_w_next;
                  m1        <= acc_m_next;
                  w2        <= w2_next;
                  m2        <= m2_next;
                  out_bin   <= bin_reg;
                  out_valid <= 1'b1;
                  out_last  <= beat_last;
                  bin_reg   <= bin_reg + 1'b1;
                  if (beat_last) begin
                     last_taken_reg <= 1'b1;
                  end
                  if (frame_err) begin
                     err <= 1'b1;
                  end
               end
            end

            DONE: begin
               done      <= 1'b0;
               state_reg <= IDLE;
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule
